// File: rtl/ppu_oam_pkg.sv
// Shared definitions for the PPU object-attribute-memory block: register map,
// write-strobe FSM encoding and the CPU read-view helper.
package ppu_oam_pkg;

    localparam logic [15:0] PPU_REG_BASE  = 16'h2000;
    localparam logic [15:0] PPU_REG_MASK  = 16'hE000;
    localparam logic [2:0]  OAMADDR_IDX   = 3'd3;
    localparam logic [2:0]  OAMDATA_IDX   = 3'd4;
    localparam logic [7:0]  ATTR_RD_MASK  = 8'hE3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } wr_state_e;

    // Attribute bytes (entry offset 2) read back with the unimplemented bits 4:2 as zero.
    function automatic logic [7:0] oam_read_view(input logic is_attr, input logic [7:0] data);
        logic [7:0] view;
        if (is_attr) begin
            view = data & ATTR_RD_MASK;
        end else begin
            view = data;
        end
        return view;
    endfunction

endpackage

// File: rtl/ppu_oam_if.sv
// CPU/DMA bus as seen by the OAM block: snooped address, write data,
// read/not-write strobe and the register read-back data.
interface ppu_oam_if;

    logic [15:0] cpumc_a_in;
    logic [7:0]  cpumc_din_in;
    logic        cpu_r_nw_in;
    logic [7:0]  cpumc_dout_out;

    modport master (
        output cpumc_a_in,
        output cpumc_din_in,
        output cpu_r_nw_in,
        input  cpumc_dout_out
    );

    modport slave (
        input  cpumc_a_in,
        input  cpumc_din_in,
        input  cpu_r_nw_in,
        output cpumc_dout_out
    );

endinterface

// File: rtl/ppu_oam_ram.sv
// 256x8 object attribute memory: one synchronous write port and two
// synchronous read ports. Reads return the pre-write contents on a collision.
module oam_ram (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       we_in,
    input  logic [7:0] waddr_in,
    input  logic [7:0] wdata_in,
    input  logic [7:0] raddr_a_in,
    output logic [7:0] rdata_a_out,
    input  logic [7:0] raddr_b_in,
    output logic [7:0] rdata_b_out
);

    logic [7:0] mem_q [0:255];
    logic [7:0] rdata_a_q;
    logic [7:0] rdata_b_q;

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (we_in) begin
            mem_q[waddr_in] <= wdata_in;
        end
    end

    // Registered read ports, cleared while reset is asserted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rdata_a_q <= 8'h00;
            rdata_b_q <= 8'h00;
        end else begin
            rdata_a_q <= mem_q[raddr_a_in];
            rdata_b_q <= mem_q[raddr_b_in];
        end
    end

    assign rdata_a_out = rdata_a_q;
    assign rdata_b_out = rdata_b_q;

endmodule

// File: rtl/ppu_oam.sv
// PPU OAM block: snoops OAMADDR/OAMDATA on the CPU bus, owns the OAM address
// pointer, and serves the sprite evaluator through a second read port.
module ppu_oam
    import ppu_oam_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    ppu_oam_if.slave   bus,
    input  logic       rendering_in,
    input  logic [7:0] spr_a_in,
    output logic [7:0] spr_d_out
);

    wr_state_e  state_q, state_d;
    logic [2:0] held_idx_q, held_idx_d;
    logic [7:0] oam_addr_q, oam_addr_d;
    logic       rd_sel_q, rd_sel_d;
    logic       rd_attr_q, rd_attr_d;
    logic       reg_sel_s;
    logic [2:0] idx_s;
    logic       wr_req_s;
    logic       accept_s;
    logic       ram_we_s;
    logic [7:0] cpu_rd_s;

    assign reg_sel_s = ((bus.cpumc_a_in & PPU_REG_MASK) == PPU_REG_BASE);
    assign idx_s     = bus.cpumc_a_in[2:0];
    assign wr_req_s  = reg_sel_s && !bus.cpu_r_nw_in &&
                       ((idx_s == OAMADDR_IDX) || (idx_s == OAMDATA_IDX));

    // Write-strobe state and registered datapath.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            held_idx_q <= 3'd0;
            oam_addr_q <= 8'h00;
            rd_sel_q   <= 1'b0;
            rd_attr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_idx_q <= held_idx_d;
            oam_addr_q <= oam_addr_d;
            rd_sel_q   <= rd_sel_d;
            rd_attr_q  <= rd_attr_d;
        end
    end

    // Next state: a write is taken once, then held until the strobe ends or moves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_req_s) begin
                    state_d = S_HELD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HELD: begin
                if (bus.cpu_r_nw_in || !reg_sel_s || (idx_s != held_idx_q)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HELD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output: the single-cycle acceptance pulse.
    always_comb begin
        accept_s = 1'b0;
        case (state_q)
            S_IDLE:  accept_s = wr_req_s;
            S_HELD:  accept_s = 1'b0;
            default: accept_s = 1'b0;
        endcase
    end

    // Pointer update, OAM write enable and read-select capture.
    always_comb begin
        oam_addr_d = oam_addr_q;
        held_idx_d = held_idx_q;
        ram_we_s   = 1'b0;
        if (accept_s) begin
            held_idx_d = idx_s;
            if (idx_s == OAMADDR_IDX) begin
                oam_addr_d = bus.cpumc_din_in;
            end else if (rendering_in) begin
                oam_addr_d = oam_addr_q + 8'd4;
            end else begin
                oam_addr_d = oam_addr_q + 8'd1;
                ram_we_s   = rst_n_in;
            end
        end else begin
            oam_addr_d = oam_addr_q;
        end
        rd_sel_d  = reg_sel_s && bus.cpu_r_nw_in && (idx_s == OAMDATA_IDX);
        rd_attr_d = (oam_addr_q[1:0] == 2'b10);
    end

    oam_ram u_oam_ram (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .we_in       (ram_we_s),
        .waddr_in    (oam_addr_q),
        .wdata_in    (bus.cpumc_din_in),
        .raddr_a_in  (oam_addr_q),
        .rdata_a_out (cpu_rd_s),
        .raddr_b_in  (spr_a_in),
        .rdata_b_out (spr_d_out)
    );

    assign bus.cpumc_dout_out = rd_sel_q ? oam_read_view(rd_attr_q, cpu_rd_s) : 8'h00;

endmodule

// File: doc/ppu_oam.md
PPU_OAM -- requirements
Module: ppu_oam

Interface
REQ-001 clk_in  input  1  system clock (100MHz); single clock domain.
REQ-002 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-003 cpumc_a_in  input  16  CPU/DMA bus address, snooped for PPU registers.
REQ-004 cpumc_din_in  input  8  write data; sprite DMA drives it with byte writes to 0x2004.
REQ-005 cpu_r_nw_in  input  1  bus read(1)/write(0).
REQ-006 cpumc_dout_out  output  8  register read data; 8'h00 when not selected.
REQ-007 rendering_in  input  1  high while PPU renders visible lines.
REQ-008 spr_a_in  input  8  sprite-evaluation read address.
REQ-009 spr_d_out  output  8  sprite-evaluation read data.

Function
REQ-010 Register decode: cpumc_a_in[15:13]==3'b001, index cpumc_a_in[2:0] (mirrored every 8 bytes across 0x2000-0x3FFF); index 3 = OAMADDR, index 4 = OAMDATA.
REQ-011 Storage: 256x8 OAM; 8-bit oam_addr register.
REQ-012 Write-strobe FSM states S_IDLE, S_HELD; a write is accepted only in S_IDLE when cpu_r_nw_in==0 and index is 3 or 4; acceptance moves to S_HELD.
REQ-013 S_HELD -> S_IDLE when cpu_r_nw_in==1 or decoded index no longer matches the held index; a write held low for N cycles is accepted exactly once.
REQ-014 Accepted OAMADDR write: oam_addr <= cpumc_din_in next cycle.
REQ-015 Accepted OAMDATA write, rendering_in==0: OAM[oam_addr] <= cpumc_din_in; oam_addr <= oam_addr+1, modulo 256 (0xFF wraps to 0x00).
REQ-016 Accepted OAMDATA write, rendering_in==1: OAM unchanged; oam_addr <= oam_addr+4, modulo 256.
REQ-017 OAMDATA read (cpu_r_nw_in==1, index 4): cpumc_dout_out = OAM[oam_addr] registered, valid the cycle after the address is presented; oam_addr not modified.
REQ-018 Read data with oam_addr[1:0]==2'b10 (attribute byte) returns bits [4:2] forced to 0.
REQ-019 Reads of any other index, and all writes, give cpumc_dout_out = 8'h00 the following cycle.
REQ-020 spr_d_out = OAM[spr_a_in] registered, 1-cycle latency, available every cycle.
REQ-021 Same-cycle OAM write and spr_a_in read of the same entry: spr_d_out returns the old data (read-before-write).
REQ-022 Accepted OAMADDR write and same-cycle DMA traffic cannot occur; no arbitration is required beyond REQ-012.
REQ-023 A back-to-back write cadence of write, idle, idle (three cycles per byte) is accepted at full rate.

Reset
REQ-024 On rst_n_in==0, immediately: oam_addr=8'h00, FSM=S_IDLE, cpumc_dout_out=8'h00, spr_d_out=8'h00.
REQ-025 OAM contents are not reset; reset mid-burst abandons the burst with no further writes.
REQ-026 First write accepted no earlier than the first rising clk_in after rst_n_in deasserts.

Structure
REQ-027 Shared package holds PPU register base 16'h2000, index constants OAMADDR=3 and OAMDATA=4, and the FSM state encoding.
REQ-028 The 256x8 array is sub-module oam_ram: one synchronous write port plus two synchronous read ports, inferable as block RAM.

Verification
REQ-029 Write 0x2003=0x10, then 0x2004=0xAB, 0x2004=0xCD -> OAM[0x10]=0xAB, OAM[0x11]=0xCD, oam_addr=0x12.
REQ-030 oam_addr=0xFF, write 0x2004=0x55 -> OAM[0xFF]=0x55, oam_addr=0x00.
REQ-031 Write 0x2004=0x77 with r_nw held low 5 cycles at oam_addr 0x20 -> only OAM[0x20] written, oam_addr=0x21.
REQ-032 OAM[0x02]=0xFF, oam_addr=0x02, read 0x2004 -> cpumc_dout_out=0xE3 the next cycle, oam_addr stays 0x02; read via mirror 0x3FFC gives the same result.
REQ-033 rendering_in=1, oam_addr=0x05, write 0x2004=0x99 -> OAM unchanged, oam_addr=0x09.
REQ-034 256-byte DMA-cadence burst from 0x00 with data = index -> spr_a_in sweep returns data = index; repeat with rst_n_in pulsed after byte 100 -> oam_addr=0x00 and bytes 101-255 unchanged.
